// File: rtl/dac_sched_pkg.sv
// Shared types for the DAC source scheduler: FSM state encoding and counter width.
package dac_sched_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/dac_src_sched.sv
// Arbitrates two accelerators onto one DAC sample path with settle and drain guard times.
// Optional round-robin tie-break when DAC_SRC_SCHED_RR_EN is defined (fixed priority to 0 otherwise).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | path released; arbitrates as soon as any request is seen
// ST_SETTLE | src_sel/ant_flag driven, waiting for the analog path to settle
// ST_STREAM | winner owns the path; samples forwarded with zero latency
// ST_DRAIN  | burst over; path held until the DAC FIFO has emptied
module dac_src_sched
   import dac_sched_pkg::*;
#(
   parameter int IQ_DATA_WIDTH = 16,
   parameter int SETTLE_CYCLES = 8,
   parameter int DRAIN_CYCLES  = 64
) (
   input  logic                       acc_clk,
   input  logic                       acc_rstn,
   input  logic                       req0,
   input  logic                       req1,
   input  logic                       ant0,
   input  logic                       ant1,
   input  logic [2*IQ_DATA_WIDTH-1:0] data0,
   input  logic [2*IQ_DATA_WIDTH-1:0] data1,
   input  logic                       valid0,
   input  logic                       valid1,
   input  logic                       last0,
   input  logic                       last1,
   output logic                       ready0,
   output logic                       ready1,
   output logic                       grant0,
   output logic                       grant1,
   output logic                       src_sel,
   output logic                       ant_flag,
   output logic [2*IQ_DATA_WIDTH-1:0] data_to_dac,
   output logic                       valid_to_dac,
   input  logic                       fulln_from_dac,
   output logic                       busy,
   output logic [CNT_W-1:0]           sample_cnt,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);

   sched_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, sample_cnt_nxt, drop_cnt_nxt;
   logic win, win_nxt, src_sel_nxt, ant_flag_nxt;
   logic arb_win, req_w, valid_w, last_w, accept;
   logic [2*IQ_DATA_WIDTH-1:0] data_w;

   assign req_w   = win ? req1   : req0;
   assign valid_w = win ? valid1 : valid0;
   assign last_w  = win ? last1  : last0;
   assign data_w  = win ? data1  : data0;
   assign accept  = (state == ST_STREAM) && valid_w && fulln_from_dac;
   assign busy    = (state != ST_IDLE);

`ifdef DAC_SRC_SCHED_RR_EN
   logic last_win;

   // Resets to 1 so requester 0 takes the first tie.
   always_ff @(posedge acc_clk or negedge acc_rstn) begin
      if (!acc_rstn)
         last_win <= 1'b1;
      else if (state == ST_IDLE && (req0 || req1))
         last_win <= arb_win;
   end

   assign arb_win = (req0 && req1) ? ~last_win : (req1 && !req0);
`else
   assign arb_win = req1 && !req0;
`endif

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      win_nxt        = win;
      src_sel_nxt    = src_sel;
      ant_flag_nxt   = ant_flag;
      sample_cnt_nxt = sample_cnt;
      drop_cnt_nxt   = drop_cnt;
      grant0         = 1'b0;
      grant1         = 1'b0;
      ready0         = 1'b0;
      ready1         = 1'b0;
      valid_to_dac   = 1'b0;
      data_to_dac    = '0;
      case (state)
         ST_IDLE: begin
            if (req0 || req1) begin
               win_nxt        = arb_win;
               ant_flag_nxt   = arb_win ? ant1 : ant0;
               src_sel_nxt    = 1'b1;
               cnt_nxt        = SETTLE_LOAD;
               sample_cnt_nxt = '0;
               state_nxt      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt == '0)
               state_nxt = ST_STREAM;
            else
               cnt_nxt = cnt - 1'b1;
         end
         ST_STREAM: begin
            grant0       = ~win;
            grant1       = win;
            ready0       = ~win & fulln_from_dac;
            ready1       = win & fulln_from_dac;
            valid_to_dac = valid_w & fulln_from_dac;
            data_to_dac  = data_w;
            if (accept && sample_cnt != '1)
               sample_cnt_nxt = sample_cnt + 1'b1;
            if (valid_w && !fulln_from_dac && drop_cnt != '1)
               drop_cnt_nxt = drop_cnt + 1'b1;
            // A dropped request aborts the burst but still drains the FIFO.
            if ((accept && last_w) || !req_w) begin
               cnt_nxt   = DRAIN_LOAD;
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cnt == '0) begin
               src_sel_nxt  = 1'b0;
               ant_flag_nxt = 1'b0;
               state_nxt    = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge acc_clk or negedge acc_rstn) begin
      if (!acc_rstn) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         win        <= 1'b0;
         src_sel    <= 1'b0;
         ant_flag   <= 1'b0;
         sample_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         win        <= win_nxt;
         src_sel    <= src_sel_nxt;
         ant_flag   <= ant_flag_nxt;
         sample_cnt <= sample_cnt_nxt;
         drop_cnt   <= drop_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_dac_src_sched.sv
// Directed bench for dac_src_sched: settle/drain timing, stalls, abort, arbitration, reset.
module tb_dac_src_sched;

   logic        acc_clk = 1'b0;
   logic        acc_rstn = 1'b0;
   logic        req0 = 0, req1 = 0, ant0 = 0, ant1 = 0;
   logic [31:0] data0 = '0, data1 = '0;
   logic        valid0 = 0, valid1 = 0, last0 = 0, last1 = 0;
   logic        fulln_from_dac = 1'b1;
   logic        ready0, ready1, grant0, grant1, src_sel, ant_flag;
   logic [31:0] data_to_dac;
   logic        valid_to_dac, busy;
   logic [15:0] sample_cnt, drop_cnt;

   int n_chk = 0;
   int n_bad = 0;
   int wr_cnt = 0;

   always #5 acc_clk = ~acc_clk;

   always @(posedge acc_clk) if (valid_to_dac) wr_cnt <= wr_cnt + 1;

   dac_src_sched dut (
      .acc_clk(acc_clk), .acc_rstn(acc_rstn),
      .req0(req0), .req1(req1), .ant0(ant0), .ant1(ant1),
      .data0(data0), .data1(data1),
      .valid0(valid0), .valid1(valid1), .last0(last0), .last1(last1),
      .ready0(ready0), .ready1(ready1), .grant0(grant0), .grant1(grant1),
      .src_sel(src_sel), .ant_flag(ant_flag),
      .data_to_dac(data_to_dac), .valid_to_dac(valid_to_dac),
      .fulln_from_dac(fulln_from_dac), .busy(busy),
      .sample_cnt(sample_cnt), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge acc_clk);
      #2;
   endtask

   task automatic wait_grant(output int n, input int budget);
      n = 0;
      while (!(grant0 || grant1) && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_idle(output int n, input int budget);
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic send(input int who, input logic [31:0] d, input logic l);
      if (who == 0) begin
         valid0 = 1'b1; data0 = d; last0 = l;
      end else begin
         valid1 = 1'b1; data1 = d; last1 = l;
      end
      #1;
      chk("fwd", {valid_to_dac, data_to_dac}, {1'b1, d});
      tick();
      valid0 = 1'b0; valid1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
   endtask

   initial begin
      int n;
      int w0;
      logic bad_g;
      logic [3:0] exp_order;
`ifdef DAC_SRC_SCHED_RR_EN
      exp_order = 4'b1010;
`else
      exp_order = 4'b0000;
`endif

      #12;
      chk("rst_ctl", {src_sel, ant_flag, grant0, grant1, ready0, ready1, valid_to_dac, busy}, 8'h00);
      chk("rst_cnt", {sample_cnt, drop_cnt}, 32'h0);
      chk("rst_data", data_to_dac, 32'h0);
      tick();
      acc_rstn = 1'b1;
      tick();
      tick();

      // 10-sample burst from requester 0 on antenna 1
      req0 = 1'b1; ant0 = 1'b1;
      tick();
      chk("t1_sel", {src_sel, ant_flag, busy, grant0}, 4'b1110);
      ant0 = 1'b0;
      wait_grant(n, 20);
      chk("t1_settle", n, 8);
      chk("t1_ant_hold", {grant0, grant1, ant_flag}, 3'b101);
      w0 = wr_cnt;
      for (int i = 0; i < 10; i++) send(0, 32'hA000_0000 + i, i == 9);
      req0 = 1'b0;
      chk("t1_scnt", sample_cnt, 10);
      chk("t1_writes", wr_cnt - w0, 10);
      chk("t1_drain", {src_sel, ant_flag, grant0, ready0, valid_to_dac}, 5'b11000);
      wait_idle(n, 100);
      chk("t1_drain_len", n, 64);
      chk("t1_release", src_sel, 0);

      // DAC FIFO full for 5 cycles
      req0 = 1'b1;
      tick();
      wait_grant(n, 20);
      chk("t2_settle", n, 8);
      w0 = wr_cnt;
      send(0, 32'h1111_1111, 1'b0);
      valid0 = 1'b1; data0 = 32'h2222_2222; fulln_from_dac = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t2_stall", {valid_to_dac, ready0}, 2'b00);
         tick();
      end
      fulln_from_dac = 1'b1;
      send(0, 32'h2222_2222, 1'b1);
      req0 = 1'b0;
      chk("t2_drop", drop_cnt, 5);
      chk("t2_scnt", sample_cnt, 2);
      chk("t2_writes", wr_cnt - w0, 2);
      wait_idle(n, 100);
      chk("t2_idle", n, 64);

      // requester 1 aborts after 3 samples; requests during DRAIN are ignored
      req1 = 1'b1; ant1 = 1'b1;
      tick();
      chk("t3_ant", {src_sel, ant_flag}, 2'b11);
      wait_grant(n, 20);
      chk("t3_settle", n, 8);
      valid0 = 1'b1;
      #1;
      chk("t3_loser", {grant0, ready0, grant1, valid_to_dac}, 4'b0010);
      valid0 = 1'b0;
      for (int i = 0; i < 3; i++) send(1, 32'h0000_00B0 + i, 1'b0);
      req1 = 1'b0;
      tick();
      chk("t3_scnt", sample_cnt, 3);
      chk("t3_abort", {busy, src_sel, grant1}, 3'b110);
      n = 0;
      bad_g = 1'b0;
      while (src_sel && n < 100) begin
         if (n == 10) req1 = 1'b1;
         if (n == 11) req1 = 1'b0;
         if (n == 50) req1 = 1'b1;
         tick();
         n++;
         if (grant0 || grant1) bad_g = 1'b1;
      end
      chk("t3_drain_len", n, 64);
      chk("t4_no_grant_drain", bad_g, 0);
      tick();
      chk("t4_rearb", {src_sel, ant_flag}, 2'b11);
      wait_grant(n, 20);
      chk("t4_grant1", {n[7:0], grant0, grant1}, {8'd8, 2'b01});
      req1 = 1'b0;
      tick();
      wait_idle(n, 100);
      chk("t4_idle", n, 64);

      // simultaneous requests, four bursts
      ant0 = 1'b0; ant1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      for (int b = 0; b < 4; b++) begin
         wait_grant(n, 30);
         chk("t5_settle", n, 9);
         chk("t5_order", {grant1, grant0}, {exp_order[b], ~exp_order[b]});
         send(grant1 ? 1 : 0, 32'hC000_0000 + b, 1'b1);
         if (b == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         wait_idle(n, 100);
         chk("t5_idle", n, 64);
      end

      // reset in the middle of a burst
      req0 = 1'b1;
      tick();
      wait_grant(n, 20);
      chk("t6_settle", n, 8);
      send(0, 32'h0000_0001, 1'b0);
      send(0, 32'h0000_0002, 1'b0);
      valid0 = 1'b1; data0 = 32'h0000_0003;
      #1;
      acc_rstn = 1'b0;
      #1;
      chk("t6_rst_ctl", {src_sel, ant_flag, grant0, grant1, ready0, ready1, valid_to_dac, busy}, 8'h00);
      chk("t6_rst_cnt", {sample_cnt, drop_cnt}, 32'h0);
      chk("t6_rst_data", data_to_dac, 32'h0);
      req0 = 1'b0; valid0 = 1'b0;
      tick();
      acc_rstn = 1'b1;
      tick();
      chk("t6_idle", busy, 0);
      req0 = 1'b1;
      tick();
      wait_grant(n, 20);
      chk("t6_settle2", n, 8);
      for (int i = 0; i < 3; i++) send(0, 32'hD000_0000 + i, i == 2);
      req0 = 1'b0;
      chk("t6_scnt", sample_cnt, 3);
      wait_idle(n, 100);
      chk("t6_drain_len", n, 64);
      chk("t6_release", src_sel, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
